// File: rtl/time_ctrl_pkg.sv
// Shared definitions for the time-set controller.
//   mode_e    : operating mode encoding driven on o_Mode
//   cnt_width : counter width for a modulus, never narrower than one bit
package time_ctrl_pkg;

    typedef enum logic [1:0] {
        ModeRun      = 2'd0,
        ModeSetTime  = 2'd1,
        ModeSetAlarm = 2'd2
    } mode_e;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_repeater.sv
// Rising-edge detector with hold-to-repeat for one debounced button.
//   clk, rst_n : clock and asynchronous active-low reset
//   btn        : debounced synchronous button level
//   clear      : drop any press in progress; a held button must be re-pressed
//   inhibit    : same effect as clear, held for as long as it is asserted
//   fire       : combinational pulse request; the parent registers it
// A press fires at once, again REPEAT_DELAY cycles later, then every
// REPEAT_PERIOD cycles while the button stays down.
module button_repeater
    import time_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic clear,
    input  logic inhibit,
    output logic fire
);

    localparam int unsigned DW = cnt_width(REPEAT_DELAY);
    localparam int unsigned PW = cnt_width(REPEAT_PERIOD);
    localparam logic [DW-1:0] DELAY_LAST  = DW'(REPEAT_DELAY - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(REPEAT_PERIOD - 1);

    logic          btn_q;
    logic          armed_q, armed_d;   // current hold began with a valid press
    logic          rep_q, rep_d;       // initial delay done, now in periodic phase
    logic [DW-1:0] dly_q, dly_d;
    logic [PW-1:0] per_q, per_d;

    always_comb begin
        armed_d = armed_q;
        rep_d   = rep_q;
        dly_d   = dly_q;
        per_d   = per_q;
        fire    = 1'b0;
        if (clear || inhibit) begin
            armed_d = 1'b0;
            rep_d   = 1'b0;
            dly_d   = '0;
            per_d   = '0;
        end else if (btn && !btn_q) begin
            fire    = 1'b1;
            armed_d = 1'b1;
            rep_d   = 1'b0;
            dly_d   = '0;
            per_d   = '0;
        end else if (btn && armed_q) begin
            if (!rep_q) begin
                if (dly_q == DELAY_LAST) begin
                    fire  = 1'b1;
                    rep_d = 1'b1;
                    per_d = '0;
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end else begin
                if (per_q == PERIOD_LAST) begin
                    fire  = 1'b1;
                    per_d = '0;
                end else begin
                    per_d = per_q + PW'(1);
                end
            end
        end else begin
            // Released, or still held after a clear: idle until a fresh press.
            armed_d = 1'b0;
            rep_d   = 1'b0;
            dly_d   = '0;
            per_d   = '0;
        end
    end

    // btn_q always tracks the input, so a clear also swallows a coincident edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q   <= 1'b0;
            armed_q <= 1'b0;
            rep_q   <= 1'b0;
            dly_q   <= '0;
            per_q   <= '0;
        end else begin
            btn_q   <= btn;
            armed_q <= armed_d;
            rep_q   <= rep_d;
            dly_q   <= dly_d;
            per_q   <= per_d;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Clock/alarm time-set controller: mode FSM, one-second divider and steering
// of minute/hour button pulses to the time or alarm counters.
//   i_Clk, i_Reset      : clock, asynchronous active-low reset
//   i_Mode_Btn          : rising edge steps RUN -> SET_TIME -> SET_ALARM -> RUN
//   i_Min_Btn, i_Hr_Btn : minute/hour set buttons (hours win when both held)
//   o_Time_Sec_Inc      : once-per-second pulse, frozen in SET_TIME
//   o_Time_Min/Hr_Inc   : set pulses in SET_TIME
//   o_Alarm_Min/Hr_Inc  : set pulses in SET_ALARM
//   o_Mode              : current mode
// All outputs are registered.
module time_set_controller
    import time_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_SEC  = 100000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Mode_Btn,
    input  logic       i_Min_Btn,
    input  logic       i_Hr_Btn,
    output logic       o_Time_Sec_Inc,
    output logic       o_Time_Min_Inc,
    output logic       o_Time_Hr_Inc,
    output logic       o_Alarm_Min_Inc,
    output logic       o_Alarm_Hr_Inc,
    output logic [1:0] o_Mode
);

    localparam int unsigned CW = cnt_width(CLKS_PER_SEC);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLKS_PER_SEC - 1);

    mode_e         mode_q, mode_d;
    logic          started_q;   // low only on the first cycle after reset
    logic          mode_btn_q;
    logic          mode_rise;
    logic [CW-1:0] div_q, div_d;
    logic          tick;
    logic          rep_clear, min_inhibit, hr_inhibit;
    logic          min_fire, hr_fire;
    logic          sec_d, tmin_d, thr_d, amin_d, ahr_d;
    logic          sec_q, tmin_q, thr_q, amin_q, ahr_q;

    // No edge on the first cycle: a button held through reset is not a press.
    assign mode_rise   = started_q & i_Mode_Btn & ~mode_btn_q;
    assign rep_clear   = ~started_q | mode_rise;
    assign hr_inhibit  = (mode_q == ModeRun);
    assign min_inhibit = hr_inhibit | i_Hr_Btn;

    button_repeater #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_min_rep (
        .clk     (i_Clk),
        .rst_n   (i_Reset),
        .btn     (i_Min_Btn),
        .clear   (rep_clear),
        .inhibit (min_inhibit),
        .fire    (min_fire)
    );

    button_repeater #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_hr_rep (
        .clk     (i_Clk),
        .rst_n   (i_Reset),
        .btn     (i_Hr_Btn),
        .clear   (rep_clear),
        .inhibit (hr_inhibit),
        .fire    (hr_fire)
    );

    // Mode state register
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            mode_q <= ModeRun;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode next state
    always_comb begin
        mode_d = mode_q;
        if (mode_rise) begin
            case (mode_q)
                ModeRun:      mode_d = ModeSetTime;
                ModeSetTime:  mode_d = ModeSetAlarm;
                ModeSetAlarm: mode_d = ModeRun;
                default:      mode_d = ModeRun;
            endcase
        end
    end

    // Second divider; restarted on leaving SET_TIME so the first second is whole.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + CW'(1);
        if (mode_rise && (mode_q == ModeSetTime)) begin
            div_d = '0;
        end
    end

    // Output steering (next values of the output registers)
    always_comb begin
        sec_d  = tick & (mode_q != ModeSetTime);
        tmin_d = min_fire & (mode_q == ModeSetTime);
        thr_d  = hr_fire & (mode_q == ModeSetTime);
        amin_d = min_fire & (mode_q == ModeSetAlarm);
        ahr_d  = hr_fire & (mode_q == ModeSetAlarm);
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            started_q  <= 1'b0;
            mode_btn_q <= 1'b0;
            div_q      <= '0;
            sec_q      <= 1'b0;
            tmin_q     <= 1'b0;
            thr_q      <= 1'b0;
            amin_q     <= 1'b0;
            ahr_q      <= 1'b0;
        end else begin
            started_q  <= 1'b1;
            mode_btn_q <= i_Mode_Btn;
            div_q      <= div_d;
            sec_q      <= sec_d;
            tmin_q     <= tmin_d;
            thr_q      <= thr_d;
            amin_q     <= amin_d;
            ahr_q      <= ahr_d;
        end
    end

    assign o_Time_Sec_Inc  = sec_q;
    assign o_Time_Min_Inc  = tmin_q;
    assign o_Time_Hr_Inc   = thr_q;
    assign o_Alarm_Min_Inc = amin_q;
    assign o_Alarm_Hr_Inc  = ahr_q;
    assign o_Mode          = mode_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios followed by
// random button/mode/reset activity, every cycle compared with a reference
// model based on hold age and elapsed-cycle arithmetic.
module tb_time_set_controller;

    localparam int C = 10;
    localparam int D = 20;
    localparam int P = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_btn = 1'b0;
    logic       min_btn = 1'b0;
    logic       hr_btn = 1'b0;
    logic       sec_inc, tmin_inc, thr_inc, amin_inc, ahr_inc;
    logic [1:0] mode;

    always #5 clk = ~clk;

    time_set_controller #(
        .CLKS_PER_SEC  (C),
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (P)
    ) dut (
        .i_Clk           (clk),
        .i_Reset         (rst_n),
        .i_Mode_Btn      (mode_btn),
        .i_Min_Btn       (min_btn),
        .i_Hr_Btn        (hr_btn),
        .o_Time_Sec_Inc  (sec_inc),
        .o_Time_Min_Inc  (tmin_inc),
        .o_Time_Hr_Inc   (thr_inc),
        .o_Alarm_Min_Inc (amin_inc),
        .o_Alarm_Hr_Inc  (ahr_inc),
        .o_Mode          (mode)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int m_mode, m_e, m_t0, age_m, age_h;
    bit first;
    bit p_mode, p_min, p_hr;
    int exp_mode;
    bit exp_sec, exp_tmin, exp_thr, exp_amin, exp_ahr;

    // A press of age 0 pulses, then at age D, D+P, D+2P, ...
    function automatic bit fires(input int age);
        return (age == 0) || (age >= D && ((age - D) % P) == 0);
    endfunction

    // Advance the model across one clock edge using the present inputs.
    task automatic model_edge();
        int div_now;
        exp_sec  = 0;
        exp_tmin = 0;
        exp_thr  = 0;
        exp_amin = 0;
        exp_ahr  = 0;
        if (!rst_n) begin
            m_mode = 0; m_e = 0; m_t0 = 0; age_m = -1; age_h = -1;
            first = 1; p_mode = 0; p_min = 0; p_hr = 0;
            exp_mode = 0;
            return;
        end
        div_now = (m_e - m_t0) % C;
        exp_sec = (div_now == C - 1) && (m_mode != 1);
        if (first) begin
            first = 0;
        end else if (mode_btn && !p_mode) begin
            if (m_mode == 1) m_t0 = m_e + 1;
            m_mode = (m_mode + 1) % 3;
            age_m = -1;
            age_h = -1;
        end else if (m_mode == 0) begin
            age_m = -1;
            age_h = -1;
        end else begin
            if (hr_btn && !p_hr)        age_h = 0;
            else if (hr_btn && age_h >= 0) age_h++;
            else                        age_h = -1;
            if (hr_btn)                    age_m = -1;
            else if (min_btn && !p_min)    age_m = 0;
            else if (min_btn && age_m >= 0) age_m++;
            else                           age_m = -1;
            if (m_mode == 1) begin
                exp_tmin = fires(age_m);
                exp_thr  = fires(age_h);
            end else begin
                exp_amin = fires(age_m);
                exp_ahr  = fires(age_h);
            end
        end
        p_mode = mode_btn;
        p_min  = min_btn;
        p_hr   = hr_btn;
        m_e++;
        exp_mode = m_mode;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("mode", int'(mode), exp_mode);
        check_eq("sec", int'(sec_inc), int'(exp_sec));
        check_eq("tmin", int'(tmin_inc), int'(exp_tmin));
        check_eq("thr", int'(thr_inc), int'(exp_thr));
        check_eq("amin", int'(amin_inc), int'(exp_amin));
        check_eq("ahr", int'(ahr_inc), int'(exp_ahr));
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset between edges and check that outputs drop without a clock.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mode", int'(mode), 0);
        check_eq("rst_sec", int'(sec_inc), 0);
        check_eq("rst_tmin", int'(tmin_inc), 0);
        check_eq("rst_thr", int'(thr_inc), 0);
        check_eq("rst_amin", int'(amin_inc), 0);
        check_eq("rst_ahr", int'(ahr_inc), 0);
        run(n);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt, other, last, gap_bad;
        int tpos[$];
        int exp_pos[5] = '{0, 20, 25, 30, 35};

        run(3);
        rst_n = 1'b1;

        // 100 cycles of RUN: ten seconds, evenly spaced, no set pulses
        cnt = 0; other = 0; last = -1; gap_bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (sec_inc) begin
                if (last >= 0 && i - last != C) gap_bad++;
                last = i;
                cnt++;
            end
            other += int'(tmin_inc) + int'(thr_inc) + int'(amin_inc) + int'(ahr_inc);
        end
        check_eq("run_sec_count", cnt, 10);
        check_eq("run_sec_gap", gap_bad, 0);
        check_eq("run_set_pulses", other, 0);

        // Mode steps 1, 2, 0; no seconds while setting; full second after exit
        mode_btn = 1'b1;
        step();
        check_eq("mode_to_1", int'(mode), 1);
        mode_btn = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            cnt += int'(sec_inc);
        end
        check_eq("settime_sec", cnt, 0);
        mode_btn = 1'b1;
        step();
        check_eq("mode_to_2", int'(mode), 2);
        mode_btn = 1'b0;
        last = -1;
        for (int i = 1; i <= 15 && last < 0; i++) begin
            step();
            if (sec_inc) last = i;
        end
        check_eq("first_sec_after_set", last, 10);
        press_mode();
        check_eq("mode_to_0", int'(mode), 0);
        press_mode();

        // SET_TIME: hold minutes for 40 cycles
        min_btn = 1'b1;
        other = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tmin_inc) tpos.push_back(i);
            other += int'(amin_inc) + int'(ahr_inc);
        end
        min_btn = 1'b0;
        run(3);
        check_eq("tmin_pulse_count", tpos.size(), 5);
        for (int i = 0; i < 5 && i < tpos.size(); i++) check_eq("tmin_pulse_pos", tpos[i], exp_pos[i]);
        check_eq("tmin_alarm_quiet", other, 0);

        // SET_ALARM: hours first, then minutes too; hours win
        press_mode();
        hr_btn = 1'b1;
        run(3);
        min_btn = 1'b1;
        cnt = 0; other = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            other += int'(amin_inc);
        end
        hr_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            other += int'(amin_inc);
        end
        check_eq("amin_blocked", other, 0);
        min_btn = 1'b0;
        run(2);
        min_btn = 1'b1;
        step();
        check_eq("amin_repress", int'(amin_inc), 1);
        min_btn = 1'b0;
        run(2);

        // Minute held across mode changes stays silent until re-pressed
        min_btn = 1'b1;
        run(5);
        mode_btn = 1'b1;
        other = 0;
        step();
        other += int'(tmin_inc) + int'(amin_inc);
        mode_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            other += int'(tmin_inc) + int'(amin_inc);
        end
        press_mode();
        for (int i = 0; i < 20; i++) begin
            step();
            other += int'(tmin_inc) + int'(amin_inc);
        end
        check_eq("held_across_mode", other, 0);
        min_btn = 1'b0;
        run(2);
        min_btn = 1'b1;
        step();
        check_eq("tmin_repress", int'(tmin_inc), 1);
        min_btn = 1'b0;
        run(2);

        // Mode edge and minute edge together: mode change only
        mode_btn = 1'b1;
        min_btn  = 1'b1;
        step();
        check_eq("same_cycle_mode", int'(mode), 2);
        check_eq("same_cycle_pulse", int'(tmin_inc) + int'(amin_inc), 0);
        mode_btn = 1'b0;
        other = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            other += int'(amin_inc) + int'(tmin_inc);
        end
        check_eq("same_cycle_quiet", other, 0);
        min_btn = 1'b0;
        run(2);

        // Reset in the middle of auto-repeat, button held through release
        min_btn = 1'b1;
        run(25);
        do_reset(3);
        other = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            other += int'(tmin_inc) + int'(thr_inc) + int'(amin_inc) + int'(ahr_inc);
        end
        check_eq("post_reset_quiet", other, 0);
        check_eq("post_reset_mode", int'(mode), 0);
        min_btn = 1'b0;
        run(2);

        // Random activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) min_btn = ~min_btn;
            if ($urandom_range(0, 29) == 0) hr_btn = ~hr_btn;
            if (mode_btn) begin
                if ($urandom_range(0, 2) == 0) mode_btn = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                mode_btn = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) do_reset($urandom_range(1, 3));
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 The block SHALL have parameter CLKS_PER_SEC, default 100000000, the number of i_Clk cycles per second tick.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50000000, the number of held cycles before auto-repeat starts.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, the number of cycles between auto-repeat pulses.
REQ-004 i_Clk  input  1  the single clock; all state is on its rising edge.
REQ-005 i_Reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to i_Clk.
REQ-006 i_Mode_Btn  input  1  debounced, synchronous level; a rising edge advances the mode.
REQ-007 i_Min_Btn  input  1  debounced, synchronous level; the minute-set button.
REQ-008 i_Hr_Btn  input  1  debounced, synchronous level; the hour-set button.
REQ-009 o_Time_Sec_Inc  output  1  one-cycle pulse; time counter seconds increment.
REQ-010 o_Time_Min_Inc / o_Time_Hr_Inc  output  1 each  one-cycle pulses; time counter minute/hour increment.
REQ-011 o_Alarm_Min_Inc / o_Alarm_Hr_Inc  output  1 each  one-cycle pulses; alarm counter minute/hour increment.
REQ-012 o_Mode  output  2  current mode: 0 RUN, 1 SET_TIME, 2 SET_ALARM; 3 is never driven.

Function
REQ-013 The mode FSM SHALL move RUN->SET_TIME->SET_ALARM->RUN, one step per i_Mode_Btn rising edge, with o_Mode updating on the cycle after the edge is sampled.
REQ-014 The second divider SHALL count 0..CLKS_PER_SEC-1 and wrap, generating an internal tick when count = CLKS_PER_SEC-1.
REQ-015 o_Time_Sec_Inc SHALL equal the registered tick in RUN and SET_ALARM, and SHALL be 0 in SET_TIME (the clock is frozen while it is being set).
REQ-016 The divider SHALL be cleared to 0 on the SET_TIME->SET_ALARM transition, so the first post-set second is a full second.
REQ-017 In RUN, i_Min_Btn and i_Hr_Btn SHALL be ignored and all min/hr outputs SHALL be 0.
REQ-018 In SET_TIME, button pulses SHALL go to o_Time_*_Inc; in SET_ALARM, they SHALL go to o_Alarm_*_Inc; the non-selected pair SHALL stay 0.
REQ-019 A button rising edge sampled at cycle N SHALL produce one pulse at cycle N+1.
REQ-020 While a button is held continuously, further pulses SHALL occur at N+1+REPEAT_DELAY, then every REPEAT_PERIOD cycles until release.
REQ-021 On release, the repeat counter SHALL clear, and no pulse SHALL be issued for the release cycle.
REQ-022 When both buttons are high, hours SHALL have priority: the minute repeater is held cleared and emits nothing until i_Hr_Btn is low and a new i_Min_Btn rising edge occurs.
REQ-023 On any mode change, both repeaters SHALL clear, and a held button SHALL NOT pulse until it is released and pressed again.
REQ-024 A mode edge and a button edge in the same cycle: the mode change SHALL win and the button edge SHALL be discarded.
REQ-025 All outputs SHALL be registered, and no output SHALL pulse for more than one consecutive cycle except auto-repeat at REPEAT_PERIOD=1.
REQ-026 Counter widths SHALL be $clog2 of the corresponding parameter, with comparisons made at full width.

Reset
REQ-027 While i_Reset=0: o_Mode=0 (RUN), all inc outputs=0, divider=0, repeat counters=0, and edge-detect registers=0.
REQ-028 A button already high when reset releases SHALL NOT count as a rising edge, so the edge registers load the live input on the first post-reset cycle.
REQ-029 Reset asserted mid-operation SHALL abort any repeat sequence with no trailing pulse.

Structure
REQ-030 Mode encodings (RUN, SET_TIME, SET_ALARM) SHALL live in the shared package time_ctrl_pkg.
REQ-031 Edge detection plus hold/auto-repeat logic SHALL be one sub-module, button_repeater (parameters REPEAT_DELAY and REPEAT_PERIOD; inputs clear and inhibit), instantiated for minutes and hours.
REQ-032 The mode FSM, divider and output steering SHALL be in the top level, at roughly 150-250 RTL lines in total.

Verification (CLKS_PER_SEC=10, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-033 RUN for 100 cycles after reset -> exactly 10 o_Time_Sec_Inc pulses, 10 cycles apart, and zero min/hr pulses.
REQ-034 Three i_Mode_Btn presses -> o_Mode goes 1,2,0; no sec pulse in mode 1; the first sec pulse after leaving SET_TIME arrives 10 cycles after the mode-2 entry.
REQ-035 In SET_TIME, hold i_Min_Btn 40 cycles from cycle N -> o_Time_Min_Inc at N+1, N+21, N+26, N+31, N+36; o_Alarm_* stays 0.
REQ-036 In SET_ALARM, i_Hr_Btn high then i_Min_Btn high 3 cycles later, both held 30 cycles -> only o_Alarm_Hr_Inc pulses; o_Alarm_Min_Inc is 0 until a re-press after hr release.
REQ-037 Hold i_Min_Btn across a mode edge -> no pulse after the change until release and re-press; the same-cycle mode/button edge yields a mode change only.
REQ-038 Assert i_Reset=0 mid-repeat with the button still high through deassertion -> all outputs 0 immediately, o_Mode=0, and no pulse after reset release.
